// File: rtl/repsub_div.sv
// repsub_div: unsigned divider by repeated subtraction.
// Dividend arrives on din with start, divisor on din the next cycle.
// Quotient/remainder are returned with a one-cycle done pulse and held until
// the next accepted start.
module repsub_div #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
    output logic             dz_err,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_D = 2'd1,
        CALC   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic             dz_q, dz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Next-state and datapath updates; busy/done are derived from the next
    // state so they are registered yet aligned with the state they describe.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quot_d  = quot_q;
        div_d   = div_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rem_d   = din;
                    quot_d  = '0;
                    dz_d    = 1'b0;
                    state_d = LOAD_D;
                end
            end
            LOAD_D: begin
                div_d = din;
                if (din == '0) begin
                    // Divide by zero: saturate quotient, keep dividend in rem.
                    dz_d    = 1'b1;
                    quot_d  = '1;
                    state_d = DONE;
                end else begin
                    state_d = CALC;
                end
            end
            CALC: begin
                if (rem_q >= div_q) begin
                    rem_d  = rem_q - div_q;
                    quot_d = quot_q + WIDTH'(1);
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            quot_q  <= '0;
            div_q   <= '0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            div_q   <= div_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign dz_err = dz_q;
    assign quot   = quot_q;
    assign rem    = rem_q;

endmodule

// File: doc/repsub_div.md
Name: repsub_div

Overview:
- Unsigned integer divider using repeated subtraction. It is the inverse companion to the team's repeated-addition multiplier.
- Self-contained controller FSM plus datapath: remainder register, divisor register, quotient counter, subtractor/comparator.
- Operands arrive on a single shared data bus on two consecutive cycles after a start pulse. Quotient and remainder are returned with a one-cycle done pulse.
- Sits beside the multiplier in the arithmetic datapath.

Parameters:
- WIDTH, 16, bit width of dividend, divisor, quotient and remainder.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- start  input  1  request; accepted only in IDLE; din carries the dividend in the same cycle.
- din  input  WIDTH  shared operand bus: dividend in the start cycle, divisor in the following cycle.
- busy  output  1  high from the cycle after start is accepted until done, inclusive.
- done  output  1  single-cycle pulse: results valid.
- dz_err  output  1  divide-by-zero flag; set with done, held until next accepted start.
- quot  output  WIDTH  quotient; held from done until next accepted start.
- rem  output  WIDTH  remainder; held from done until next accepted start.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - State goes to IDLE.
  - busy=0, done=0, dz_err=0, quot=0, rem=0; internal divisor register=0.
  - Reset is honoured in any state, including mid-division; any partial result is discarded.
- States: IDLE, LOAD_D, CALC, DONE. All outputs are registered.
- IDLE:
  - start=1 loads rem<=din (dividend), clears quot<=0 and dz_err<=0, then goes to LOAD_D.
  - start=0 holds all outputs.
- LOAD_D:
  - din is captured as the divisor.
  - If din==0: dz_err<=1, quot<=all ones, rem keeps the dividend, go to DONE.
  - Otherwise go to CALC. start is ignored here.
- CALC: one subtraction per cycle.
  - If rem>=divisor: rem<=rem-divisor, quot<=quot+1, stay in CALC.
  - Otherwise go to DONE, leaving quot and rem unchanged.
  - Comparison and subtraction are unsigned at WIDTH bits. quot cannot overflow because quot<=dividend. start is ignored.
- DONE:
  - done=1 for exactly this one cycle; busy=1; then return to IDLE unconditionally.
  - start asserted during DONE is ignored; the next request must come in IDLE.
- busy is high in LOAD_D, CALC and DONE; done is high only in DONE.
- Latency, counting the start-accept cycle as cycle 0:
  - done is high in cycle Q+3 for a non-zero divisor, where Q is the quotient.
  - done is high in cycle 2 for a zero divisor.
  - Worst case is dividend=2^WIDTH-1, divisor=1: done in cycle 2^WIDTH+2.
- Boundary cases:
  - dividend<divisor: Q=0, rem=dividend, done in cycle 3.
  - dividend==divisor: Q=1, rem=0.
  - dividend=0 with non-zero divisor: Q=0, rem=0, done in cycle 3.
- Results stay stable in IDLE after done until the next accepted start, which clears quot and dz_err and overwrites rem.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 cycles, release, start=0 for 5 cycles -> busy=0, done=0, quot=0, rem=0, dz_err=0 throughout.
- Nominal: start with din=100, then din=7 -> done in cycle 17 only, quot=14, rem=2, dz_err=0; values held 10 idle cycles later.
- Small dividend and equality: 5/9 -> quot=0, rem=5, done in cycle 3. 9/9 -> quot=1, rem=0, done in cycle 4.
- Divide by zero: 1234/0 -> done in cycle 2, dz_err=1, quot=16'hFFFF, rem=1234. A following 20/4 -> dz_err clears at start; quot=5, rem=0.
- start while busy: start 1000/3, pulse start with din=50 during CALC and again during DONE -> both ignored; quot=333, rem=1, single done pulse in cycle 336.
- Reset mid-operation: start 60000/1, drop rst_n for 1 cycle at cycle 100 -> all outputs 0, no done. A fresh 65535/65535 -> quot=1, rem=0, done in cycle 4.
